// File: rtl/trip_controller.sv
// trip_controller: registered drive/computer-power sequencer.
// Debounces overheat, enforces cooldown, holds for refuel.
module trip_controller #(
   parameter int DEBOUNCE    = 3,
   parameter int COOL_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_trip,
   input  logic       cpu_overheated,
   input  logic       arrived,
   input  logic       gas_tank_empty,
   input  logic       refuel_done,
   output logic       keep_driving,
   output logic       shut_off_computer,
   output logic [2:0] state,
   output logic [3:0] fuel_stops
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DRIVE    = 3'd1,
      REFUEL   = 3'd2,
      COOLDOWN = 3'd3,
      DONE     = 3'd4
   } state_t;

   // Last count value before the streak completes; comparing
   // against it avoids ever holding the full parameter value.
   localparam logic [3:0] HOT_LAST  = 4'(DEBOUNCE - 1);
   localparam logic [7:0] COOL_LAST = 8'(COOL_CYCLES - 1);

   state_t     st;
   logic [3:0] hot_cnt;
   logic [7:0] cool_cnt;
   logic       hot_done;
   logic       cool_done;
   logic [3:0] stops_inc;

   // Streak-completion and saturating fuel-stop increment.
   always_comb begin
      hot_done  = cpu_overheated && (hot_cnt == HOT_LAST);
      cool_done = !cpu_overheated && (cool_cnt == COOL_LAST);
      stops_inc = (fuel_stops == 4'hF) ? fuel_stops
                                       : fuel_stops + 4'd1;
   end

   assign state = st;

   // State machine with counters and outputs registered together,
   // so outputs always match the state they were decoded for.
   always_ff @(posedge clk) begin
      if (rst) begin
         st                <= IDLE;
         keep_driving      <= 1'b0;
         shut_off_computer <= 1'b0;
         fuel_stops        <= 4'd0;
         hot_cnt           <= 4'd0;
         cool_cnt          <= 8'd0;
      end else begin
         case (st)
            IDLE: begin
               hot_cnt  <= 4'd0;
               cool_cnt <= 8'd0;
               if (start_trip) begin
                  st                <= DRIVE;
                  keep_driving      <= 1'b1;
                  shut_off_computer <= 1'b0;
                  fuel_stops        <= 4'd0;
               end
            end

            DRIVE: begin
               cool_cnt <= 8'd0;
               if (arrived) begin
                  st                <= DONE;
                  keep_driving      <= 1'b0;
                  shut_off_computer <= 1'b1;
                  hot_cnt           <= 4'd0;
               end else if (gas_tank_empty) begin
                  st                <= REFUEL;
                  keep_driving      <= 1'b0;
                  shut_off_computer <= 1'b0;
                  fuel_stops        <= stops_inc;
                  hot_cnt           <= 4'd0;
               end else if (hot_done) begin
                  st                <= COOLDOWN;
                  keep_driving      <= 1'b1;
                  shut_off_computer <= 1'b1;
                  hot_cnt           <= 4'd0;
               end else if (cpu_overheated) begin
                  hot_cnt <= hot_cnt + 4'd1;
               end else begin
                  hot_cnt <= 4'd0;
               end
            end

            COOLDOWN: begin
               hot_cnt <= 4'd0;
               if (arrived) begin
                  st                <= DONE;
                  keep_driving      <= 1'b0;
                  shut_off_computer <= 1'b1;
                  cool_cnt          <= 8'd0;
               end else if (gas_tank_empty) begin
                  st                <= REFUEL;
                  keep_driving      <= 1'b0;
                  shut_off_computer <= 1'b0;
                  fuel_stops        <= stops_inc;
                  cool_cnt          <= 8'd0;
               end else if (cool_done) begin
                  st                <= DRIVE;
                  keep_driving      <= 1'b1;
                  shut_off_computer <= 1'b0;
                  cool_cnt          <= 8'd0;
               end else if (cpu_overheated) begin
                  cool_cnt <= 8'd0;
               end else begin
                  cool_cnt <= cool_cnt + 8'd1;
               end
            end

            REFUEL: begin
               hot_cnt  <= 4'd0;
               cool_cnt <= 8'd0;
               if (refuel_done) begin
                  st                <= DRIVE;
                  keep_driving      <= 1'b1;
                  shut_off_computer <= 1'b0;
               end
            end

            DONE: begin
               hot_cnt  <= 4'd0;
               cool_cnt <= 8'd0;
               if (start_trip) begin
                  st                <= DRIVE;
                  keep_driving      <= 1'b1;
                  shut_off_computer <= 1'b0;
                  fuel_stops        <= 4'd0;
               end
            end

            default: begin
               st                <= IDLE;
               keep_driving      <= 1'b0;
               shut_off_computer <= 1'b0;
               hot_cnt           <= 4'd0;
               cool_cnt          <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trip_controller.sv
// tb_trip_controller: directed checks of trip_controller
// with defaults DEBOUNCE=3, COOL_CYCLES=8.
module tb_trip_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_trip;
   logic       cpu_overheated;
   logic       arrived;
   logic       gas_tank_empty;
   logic       refuel_done;
   logic       keep_driving;
   logic       shut_off_computer;
   logic [2:0] state;
   logic [3:0] fuel_stops;

   int tests = 0;
   int fails = 0;

   trip_controller dut (
      .clk               (clk),
      .rst               (rst),
      .start_trip        (start_trip),
      .cpu_overheated    (cpu_overheated),
      .arrived           (arrived),
      .gas_tank_empty    (gas_tank_empty),
      .refuel_done       (refuel_done),
      .keep_driving      (keep_driving),
      .shut_off_computer (shut_off_computer),
      .state             (state),
      .fuel_stops        (fuel_stops)
   );

   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] st,
                          input logic kd, input logic so,
                          input logic [3:0] fs);
      chk({tag, ".state"}, 8'(state), 8'(st));
      chk({tag, ".kd"}, 8'(keep_driving), 8'(kd));
      chk({tag, ".so"}, 8'(shut_off_computer), 8'(so));
      chk({tag, ".fs"}, 8'(fuel_stops), 8'(fs));
   endtask

   initial begin
      // reset with every input high
      rst = 1; start_trip = 1; cpu_overheated = 1;
      arrived = 1; gas_tank_empty = 1; refuel_done = 1;
      step(2);
      chk_all("reset", 3'd0, 0, 0, 4'd0);

      rst = 0; start_trip = 1; cpu_overheated = 0;
      arrived = 0; gas_tank_empty = 0; refuel_done = 0;
      step();
      chk_all("start", 3'd1, 1, 0, 4'd0);
      start_trip = 0;

      // debounce: 2 high, 1 low, 3 high
      cpu_overheated = 1; step(2);
      chk("deb_2hi", 8'(state), 8'd1);
      cpu_overheated = 0; step();
      chk("deb_lo", 8'(state), 8'd1);
      cpu_overheated = 1; step(2);
      chk("deb_2hi_again", 8'(state), 8'd1);
      step();
      chk_all("deb_cool", 3'd3, 1, 1, 4'd0);

      // cooldown restart: 5 low, 1 high, 8 low
      cpu_overheated = 0; step(5);
      chk("cool_5lo", 8'(state), 8'd3);
      cpu_overheated = 1; step();
      chk("cool_hi", 8'(state), 8'd3);
      cpu_overheated = 0; step(7);
      chk("cool_7lo", 8'(state), 8'd3);
      step();
      chk_all("cool_exit", 3'd1, 1, 0, 4'd0);

      // refuel, arrived and overheat ignored while waiting
      gas_tank_empty = 1; step();
      chk_all("refuel", 3'd2, 0, 0, 4'd1);
      gas_tank_empty = 0; arrived = 1; cpu_overheated = 1;
      step(4);
      chk("refuel_hold", 8'(state), 8'd2);
      arrived = 0; cpu_overheated = 0; refuel_done = 1; step();
      chk_all("refuel_done", 3'd1, 1, 0, 4'd1);
      refuel_done = 0;

      // arrived beats gas_tank_empty
      arrived = 1; gas_tank_empty = 1; step();
      chk_all("arr_gas", 3'd4, 0, 1, 4'd1);
      arrived = 0; gas_tank_empty = 0; step(2);
      chk("done_hold_fs", 8'(fuel_stops), 8'd1);

      // restart from DONE, start held for two edges
      start_trip = 1; step();
      chk_all("done_start", 3'd1, 1, 0, 4'd0);
      step();
      chk("start_held", 8'(state), 8'd1);
      start_trip = 0;

      // gas beats a completing debounce
      cpu_overheated = 1; step(2);
      gas_tank_empty = 1; step();
      chk_all("gas_deb", 3'd2, 0, 0, 4'd1);
      gas_tank_empty = 0; cpu_overheated = 0;
      refuel_done = 1; step();
      refuel_done = 0;
      chk("gas_deb_back", 8'(state), 8'd1);

      // new trip then 16 refuel loops saturate at 15
      arrived = 1; step(); arrived = 0;
      start_trip = 1; step(); start_trip = 0;
      chk("trip2_fs", 8'(fuel_stops), 8'd0);
      for (int i = 0; i < 16; i++) begin
         gas_tank_empty = 1; step();
         gas_tank_empty = 0; refuel_done = 1; step();
         refuel_done = 0;
         if (i == 14) chk("sat_15", 8'(fuel_stops), 8'd15);
      end
      chk_all("sat_16", 3'd1, 1, 0, 4'd15);

      // in cooldown, arrived beats a completing cool count
      cpu_overheated = 1; step(3);
      chk("cool2", 8'(state), 8'd3);
      cpu_overheated = 0; step(7);
      arrived = 1; step(); arrived = 0;
      chk_all("cool_arr", 3'd4, 0, 1, 4'd15);

      // gas in cooldown increments stops
      start_trip = 1; step(); start_trip = 0;
      cpu_overheated = 1; step(3); cpu_overheated = 0;
      gas_tank_empty = 1; step(); gas_tank_empty = 0;
      chk_all("cool_gas", 3'd2, 0, 0, 4'd1);

      // reset mid-refuel overrides refuel_done
      rst = 1; refuel_done = 1; step();
      rst = 0; refuel_done = 0;
      chk_all("rst_refuel", 3'd0, 0, 0, 4'd0);
      step();
      chk("idle_hold", 8'(state), 8'd0);

      // reset mid-cooldown clears the cool counter
      start_trip = 1; step(); start_trip = 0;
      cpu_overheated = 1; step(3);
      cpu_overheated = 0; step(5);
      chk("pre_rst_cool", 8'(state), 8'd3);
      rst = 1; step(); rst = 0;
      chk_all("rst_cool", 3'd0, 0, 0, 4'd0);

      // after restart, full debounce and full cooldown needed
      start_trip = 1; step(); start_trip = 0;
      cpu_overheated = 1; step(2);
      chk("post_rst_2hi", 8'(state), 8'd1);
      step();
      chk("post_rst_cool", 8'(state), 8'd3);
      cpu_overheated = 0; step(7);
      chk("post_rst_7lo", 8'(state), 8'd3);
      step();
      chk_all("post_rst_exit", 3'd1, 1, 0, 4'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
